halftone_stream_converter: RTL

- Sequential, parametrised successor to the 6x8 combinational image converter.
- Accepts greyscale pixels one per clock over a valid/ready handshake, in raster order.
- Performs Floyd-Steinberg error-diffusion halftoning with a two-row error buffer.
- Emits one COLS-bit halftone pixel value (HTPV) row per image row, with its own valid/ready handshake and end-of-frame flag.

---
 rtl/halftone_stream_converter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/halftone_stream_converter.sv
// Streaming Floyd-Steinberg halftoner: raster greyscale pixels in, one COLS-bit
// halftone row out per image row, with a one-row skid slot for a stalled consumer.
module halftone_stream_converter #(
  parameter int PIX_W  = 8,
  parameter int COLS   = 8,
  parameter int ROWS   = 6,
  parameter int THRESH = 128,
  localparam int IW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [1:COLS]    htpv_row,
  output logic [IW-1:0]    row_index,
  output logic             row_valid,
  input  logic             row_ready,
  output logic             frame_done
);

  localparam int EW = PIX_W + 3;
  localparam int CW = $clog2(COLS);
  localparam logic signed [EW-1:0] TH_S  = EW'(THRESH);
  localparam logic signed [EW-1:0] MAX_S = EW'((1 << PIX_W) - 1);

  typedef enum logic {RUN, HOLD} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]        col;
  logic [IW-1:0]        row;
  logic signed [EW-1:0] e_right;
  logic signed [EW-1:0] cur_err [COLS];
  logic signed [EW-1:0] nxt_err [COLS];
  logic signed [EW-1:0] nxt_sum [COLS];
  logic [COLS-1:0]      asm_row, row_bits, pend_row;
  logic [IW-1:0]        pend_idx;
  logic                 pend_done;
  logic                 accept, last_col, last_row, row_done, out_free, b;
  logic signed [EW-1:0] v, e, w7, w5, w3, w1;

  // floor(k*x/16) with enough headroom that the product never wraps
  function automatic logic signed [EW-1:0] frac16(input logic signed [EW-1:0] x,
                                                  input logic [2:0] k);
    logic signed [EW+3:0] xs, ks, p;
    xs = (EW+4)'(x);
    ks = (EW+4)'(k);
    p  = (xs * ks) >>> 4;
    return p[EW-1:0];
  endfunction

  assign pix_ready = (state_q == RUN);
  assign accept    = pix_valid && pix_ready && !clear;
  assign last_col  = (col == CW'(COLS - 1));
  assign last_row  = (row == IW'(ROWS - 1));
  assign row_done  = accept && last_col;
  assign out_free  = !row_valid || row_ready;

  always_comb begin
    v  = $signed({3'b000, pix_in}) + e_right + cur_err[col];
    b  = (v >= TH_S);
    e  = b ? v - MAX_S : v;
    w7 = frac16(e, 3'd7);
    w5 = frac16(e, 3'd5);
    w3 = frac16(e, 3'd3);
    w1 = frac16(e, 3'd1);
    // leftmost column lands in the MSB so it maps onto htpv_row[1]
    row_bits = asm_row;
    row_bits[CW'(COLS - 1) - col] = b;
    for (int j = 0; j < COLS; j++) begin
      nxt_sum[j] = nxt_err[j];
      if (j == int'(col) - 1) nxt_sum[j] = nxt_sum[j] + w3;
      if (j == int'(col))     nxt_sum[j] = nxt_sum[j] + w5;
      if (j == int'(col) + 1) nxt_sum[j] = nxt_sum[j] + w1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = RUN;
    else begin
      case (state_q)
        RUN:     if (row_done && !out_free) state_d = HOLD;
        HOLD:    if (row_ready) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      e_right    <= '0;
      asm_row    <= '0;
      pend_row   <= '0;
      pend_idx   <= '0;
      pend_done  <= 1'b0;
      htpv_row   <= '0;
      row_index  <= '0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int j = 0; j < COLS; j++) begin
        cur_err[j] <= '0;
        nxt_err[j] <= '0;
      end
    end else if (clear) begin
      col        <= '0;
      row        <= '0;
      e_right    <= '0;
      asm_row    <= '0;
      pend_row   <= '0;
      pend_idx   <= '0;
      pend_done  <= 1'b0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int j = 0; j < COLS; j++) begin
        cur_err[j] <= '0;
        nxt_err[j] <= '0;
      end
    end else begin
      // output register: HOLD drains the skid slot, RUN loads or parks new rows
      if (state_q == HOLD) begin
        if (row_ready) begin
          htpv_row   <= pend_row;
          row_index  <= pend_idx;
          frame_done <= pend_done;
        end
      end else if (row_done) begin
        if (out_free) begin
          htpv_row   <= row_bits;
          row_index  <= row;
          frame_done <= last_row;
          row_valid  <= 1'b1;
        end else begin
          pend_row  <= row_bits;
          pend_idx  <= row;
          pend_done <= last_row;
        end
      end else if (row_valid && row_ready) begin
        row_valid  <= 1'b0;
        frame_done <= 1'b0;
      end

      if (accept) begin
        asm_row <= row_bits;
        if (last_col) begin
          col     <= '0;
          e_right <= '0;
          row     <= last_row ? '0 : row + 1'b1;
          for (int j = 0; j < COLS; j++) begin
            cur_err[j] <= last_row ? '0 : nxt_sum[j];
            nxt_err[j] <= '0;
          end
        end else begin
          col     <= col + 1'b1;
          e_right <= w7;
          for (int j = 0; j < COLS; j++) nxt_err[j] <= nxt_sum[j];
        end
      end
    end
  end

endmodule
